// File: rtl/reg_file_pkg.sv
// Shared register-file types plus the writeback-arbiter request type.
// REG_ADDR_WIDTH defaults to 5 (32 architectural registers) unless set by the build.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package reg_file_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] arch_reg;

    typedef struct packed {
        logic [`REG_ADDR_WIDTH-1:0] addr_rd;
        logic                       write_enable;
    } reg_file_write_params_t;

    typedef struct packed {
        logic [`REG_ADDR_WIDTH-1:0] addr_rd;
        arch_reg                    data;
    } wb_req_t;

    localparam int WB_MAX_SRC = 8;

endpackage

// File: rtl/reg_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from req, scanning upward from a pointer that
// moves to just past the last winner.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic             found;

    // Explicit wrap keeps non-power-of-2 NUM_REQ correct.
    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        found   = 1'b0;
        gnt_idx = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req[j]) begin
                gnt[j]  = 1'b1;
                found   = 1'b1;
                gnt_idx = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (found) begin
            if (gnt_idx == IDX_W'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= gnt_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback port arbiter: round-robin among NUM_SRC requesters into one staged write.
// Optional per-source stall counters are built when REG_WB_STATS_EN is defined.
module reg_wb_arbiter
    import reg_file_pkg::*;
#(
    parameter int NUM_SRC = 3
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic [NUM_SRC-1:0]                     src_valid,
    input  logic [NUM_SRC-1:0][`REG_ADDR_WIDTH-1:0] src_addr_rd,
    input  arch_reg [NUM_SRC-1:0]                  src_data,
    output logic [NUM_SRC-1:0]                     src_ready,
    output reg_file_write_params_t                 write_params,
    output arch_reg                                data_rd,
    output logic [2**`REG_ADDR_WIDTH-1:0]          wb_busy_mask
`ifdef REG_WB_STATS_EN
    ,
    output logic [NUM_SRC-1:0][31:0]               stall_cnt
`endif
);

    wb_req_t sel_req;
    wb_req_t stage_req;
    logic    stage_we;
    logic    grant_any;

    rr_arbiter #(
        .NUM_REQ (NUM_SRC)
    ) u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (src_valid),
        .gnt     (src_ready)
    );

    assign grant_any = |src_ready;

    always_comb begin
        sel_req = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_ready[i]) begin
                sel_req.addr_rd = src_addr_rd[i];
                sel_req.data    = src_data[i];
            end
        end
    end

    // Writes to x0 are accepted but never enabled, so they cannot mark x0 busy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_req <= '0;
            stage_we  <= 1'b0;
        end else if (grant_any) begin
            stage_req <= sel_req;
            stage_we  <= (sel_req.addr_rd != '0);
        end else begin
            stage_we  <= 1'b0;
        end
    end

    assign write_params.addr_rd      = stage_req.addr_rd;
    assign write_params.write_enable = stage_we;
    assign data_rd                   = stage_req.data;

    always_comb begin
        wb_busy_mask = '0;
        if (stage_we) begin
            wb_busy_mask[stage_req.addr_rd] = 1'b1;
        end
    end

`ifdef REG_WB_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_valid[i] && !src_ready[i] && (stall_cnt[i] != 32'hFFFF_FFFF)) begin
                    stall_cnt[i] <= stall_cnt[i] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter with a behavioural register file on its write port.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module tb_reg_wb_arbiter;
    import reg_file_pkg::*;

    localparam int NS = 3;
    localparam int AW = `REG_ADDR_WIDTH;

    logic                        clock;
    logic                        reset_n;
    logic [NS-1:0]               src_valid;
    logic [NS-1:0][AW-1:0]       src_addr_rd;
    arch_reg [NS-1:0]            src_data;
    logic [NS-1:0]               src_ready;
    reg_file_write_params_t      write_params;
    arch_reg                     data_rd;
    logic [2**AW-1:0]            wb_busy_mask;
`ifdef REG_WB_STATS_EN
    logic [NS-1:0][31:0]         stall_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    arch_reg regs [2**AW];

    reg_wb_arbiter #(
        .NUM_SRC (NS)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .src_valid    (src_valid),
        .src_addr_rd  (src_addr_rd),
        .src_data     (src_data),
        .src_ready    (src_ready),
        .write_params (write_params),
        .data_rd      (data_rd),
        .wb_busy_mask (wb_busy_mask)
`ifdef REG_WB_STATS_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural register file fed by the DUT write port; it has no reset.
    always @(posedge clock) begin
        if (write_params.write_enable) begin
            regs[write_params.addr_rd] <= data_rd;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [AW-1:0] a, input arch_reg d);
        src_valid[i]   = v;
        src_addr_rd[i] = a;
        src_data[i]    = d;
    endtask

    task automatic clear_src();
        src_valid   = '0;
        src_addr_rd = '0;
        src_data    = '0;
    endtask

    initial begin
        logic [NS-1:0] exp_rdy [6];
        logic [AW-1:0] exp_adr [6];
        exp_rdy = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_adr = '{5'd5, 5'd6, 5'd8, 5'd5, 5'd6, 5'd8};
        for (int i = 0; i < 2**AW; i++) regs[i] = '0;
        reset_n = 1'b0;
        clear_src();
        tick();
        tick();
        chk("rst_we",    64'(write_params.write_enable), 64'd0);
        chk("rst_addr",  64'(write_params.addr_rd), 64'd0);
        chk("rst_data",  64'(data_rd), 64'd0);
        chk("rst_mask",  64'(wb_busy_mask), 64'd0);
        chk("rst_ready", 64'(src_ready), 64'd0);
`ifdef REG_WB_STATS_EN
        chk("rst_stall1", 64'(stall_cnt[1]), 64'd0);
`endif
        reset_n = 1'b1;
        tick();

        // Single write x7 from src0
        set_src(0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        #1;
        chk("single_ready", 64'(src_ready), 64'b001);
        tick();
        clear_src();
        chk("single_we",   64'(write_params.write_enable), 64'd1);
        chk("single_addr", 64'(write_params.addr_rd), 64'd7);
        chk("single_data", 64'(data_rd), 64'hDEAD_BEEF);
        chk("single_busy", 64'(wb_busy_mask), 64'h80);
        tick();
        chk("single_we_off",   64'(write_params.write_enable), 64'd0);
        chk("single_busy_off", 64'(wb_busy_mask), 64'd0);
        chk("single_reg7",     64'(regs[7]), 64'hDEAD_BEEF);

        // src1 -> x0 (pointer now 1)
        set_src(1, 1'b1, 5'd0, 32'h1234);
        #1;
        chk("x0_ready", 64'(src_ready), 64'b010);
        tick();
        clear_src();
        chk("x0_we",   64'(write_params.write_enable), 64'd0);
        chk("x0_busy", 64'(wb_busy_mask), 64'd0);
        tick();
        chk("x0_reg0", 64'(regs[0]), 64'd0);

        // Same destination x9 from src0 and src2 with pointer at 2
        set_src(0, 1'b1, 5'd9, 32'h11);
        set_src(2, 1'b1, 5'd9, 32'h22);
        #1;
        chk("same_ready_a", 64'(src_ready), 64'b100);
        tick();
        set_src(2, 1'b0, 5'd0, 32'h0);
        chk("same_data_a", 64'(data_rd), 64'h22);
        #1;
        chk("same_ready_b", 64'(src_ready), 64'b001);
        tick();
        clear_src();
        chk("same_data_b", 64'(data_rd), 64'h11);
        chk("same_we_b",   64'(write_params.write_enable), 64'd1);
        tick();
        chk("same_reg9", 64'(regs[9]), 64'h11);

        // All three valid from reset: strict rotation, no idle write cycles
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        set_src(0, 1'b1, 5'd5, 32'hA0);
        set_src(1, 1'b1, 5'd6, 32'hB1);
        set_src(2, 1'b1, 5'd8, 32'hC2);
        for (int s = 0; s < 6; s++) begin
            #1;
            chk($sformatf("rr_ready%0d", s), 64'(src_ready), 64'(exp_rdy[s]));
            tick();
            chk($sformatf("rr_we%0d", s),   64'(write_params.write_enable), 64'd1);
            chk($sformatf("rr_addr%0d", s), 64'(write_params.addr_rd), 64'(exp_adr[s]));
        end
        clear_src();
        tick();
        chk("rr_reg5", 64'(regs[5]), 64'hA0);
        chk("rr_reg6", 64'(regs[6]), 64'hB1);
        chk("rr_reg8", 64'(regs[8]), 64'hC2);

        // Reset while stage holds a write to x5: it must be discarded
        set_src(0, 1'b1, 5'd5, 32'h55);
        tick();
        clear_src();
        chk("mid_we_before", 64'(write_params.write_enable), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_we_drop",   64'(write_params.write_enable), 64'd0);
        chk("mid_busy_drop", 64'(wb_busy_mask), 64'd0);
        chk("mid_data_drop", 64'(data_rd), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("mid_reg5", 64'(regs[5]), 64'hA0);
        chk("mid_we_after", 64'(write_params.write_enable), 64'd0);

`ifdef REG_WB_STATS_EN
        // src0 and src1 contend from pointer 0: each is blocked on alternate cycles
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        set_src(0, 1'b1, 5'd3, 32'h3);
        set_src(1, 1'b1, 5'd4, 32'h4);
        for (int s = 0; s < 4; s++) tick();
        clear_src();
        chk("stall_src1", 64'(stall_cnt[1]), 64'd2);
        chk("stall_src0", 64'(stall_cnt[0]), 64'd2);
        chk("stall_src2", 64'(stall_cnt[2]), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
